// File: rtl/pong_pkg.sv
// Shared definitions for the pong game sequencer: state codes, winner codes,
// ball centre position and default goal rows.
package pong_pkg;

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StServe = 3'd1;
    localparam logic [2:0] StPlay  = 3'd2;
    localparam logic [2:0] StPoint = 3'd3;
    localparam logic [2:0] StOver  = 3'd4;

    localparam logic [1:0] WinNone = 2'b00;
    localparam logic [1:0] WinP1   = 2'b01;
    localparam logic [1:0] WinP2   = 2'b10;

    localparam logic [9:0] BallCentreX = 10'd376;
    localparam logic [8:0] BallCentreY = 9'd232;

    localparam int unsigned TopGoalYDef = 12;
    localparam int unsigned BotGoalYDef = 452;

    // A frame count of zero would never expire, so it behaves as one frame.
    function automatic int unsigned frames_or_one(input int unsigned frames);
        return (frames == 0) ? 1 : frames;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
        int unsigned m;
        m = frames_or_one((a > b) ? a : b);
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/pong_btn_sync.sv
// Two-flop synchronizer for a raw push-button followed by a registered
// rising-edge detector producing a single-cycle pulse.
module pong_btn_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    output logic pulse_o
);

    logic meta_q, sync_q, prev_q, pulse_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q  <= 1'b0;
            sync_q  <= 1'b0;
            prev_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            meta_q  <= btn_i;
            sync_q  <= meta_q;
            prev_q  <= sync_q;
            pulse_q <= sync_q & ~prev_q;
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: serve/play/point/game-over control, goal detection and
// score keeping. Every output comes straight from a register.
module pong_game_ctrl
    import pong_pkg::*;
#(
    parameter int unsigned WIN_SCORE    = 7,
    parameter int unsigned SERVE_FRAMES = 60,
    parameter int unsigned POINT_FRAMES = 90,
    parameter int unsigned TOP_GOAL_Y   = TopGoalYDef,
    parameter int unsigned BOT_GOAL_Y   = BotGoalYDef
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       frame_tick_i,
    input  logic [8:0] ball_y_i,
    input  logic       start_btn_i,
    output logic       ball_run_o,
    output logic       ball_load_o,
    output logic       serve_dir_y_o,
    output logic [3:0] score1_o,
    output logic [3:0] score2_o,
    output logic [1:0] winner_o,
    output logic [2:0] state_o
);

    localparam int unsigned CntW = cnt_width(SERVE_FRAMES, POINT_FRAMES);
    localparam logic [CntW-1:0] ServeLoad = CntW'(frames_or_one(SERVE_FRAMES));
    localparam logic [CntW-1:0] PointLoad = CntW'(frames_or_one(POINT_FRAMES));
    localparam logic [CntW-1:0] CntOne    = CntW'(1);
    localparam logic [3:0]      WinVal    = 4'(WIN_SCORE);
    localparam logic [8:0]      TopY      = 9'(TOP_GOAL_Y);
    localparam logic [8:0]      BotY      = 9'(BOT_GOAL_Y);

    logic            start_pe;
    logic [2:0]      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [3:0]      score1_q, score1_d, score2_q, score2_d;
    logic [1:0]      winner_q, winner_d;
    logic            run_q, run_d, load_q, load_d, dir_q, dir_d;
    logic            top_goal, bot_goal, cnt_last;

    pong_btn_sync u_start_sync (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .btn_i   (start_btn_i),
        .pulse_o (start_pe)
    );

    assign top_goal = (ball_y_i <= TopY);
    assign bot_goal = (ball_y_i >= BotY);
    assign cnt_last = (cnt_q == CntOne);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        score1_d = score1_q;
        score2_d = score2_q;
        winner_d = winner_q;
        dir_d    = dir_q;
        load_d   = 1'b0;

        case (state_q)
            StIdle: begin
                // A coincident frame_tick is deliberately ignored: the load wins.
                if (start_pe) begin
                    load_d  = 1'b1;
                    cnt_d   = ServeLoad;
                    state_d = StServe;
                end
            end
            StServe: begin
                if (frame_tick_i) begin
                    if (cnt_last) begin
                        cnt_d   = '0;
                        state_d = StPlay;
                    end else begin
                        cnt_d = cnt_q - CntOne;
                    end
                end
            end
            StPlay: begin
                if (frame_tick_i) begin
                    if (top_goal) begin
                        score1_d = score1_q + 4'd1;
                        dir_d    = 1'b1;
                        cnt_d    = PointLoad;
                        state_d  = StPoint;
                    end else if (bot_goal) begin
                        score2_d = score2_q + 4'd1;
                        dir_d    = 1'b0;
                        cnt_d    = PointLoad;
                        state_d  = StPoint;
                    end
                end
            end
            StPoint: begin
                if (frame_tick_i) begin
                    if (!cnt_last) begin
                        cnt_d = cnt_q - CntOne;
                    end else if (score1_q == WinVal || score2_q == WinVal) begin
                        cnt_d    = '0;
                        winner_d = (score1_q == WinVal) ? WinP1 : WinP2;
                        state_d  = StOver;
                    end else begin
                        load_d  = 1'b1;
                        cnt_d   = ServeLoad;
                        state_d = StServe;
                    end
                end
            end
            StOver: begin
                if (start_pe) begin
                    score1_d = '0;
                    score2_d = '0;
                    winner_d = WinNone;
                    dir_d    = 1'b0;
                    load_d   = 1'b1;
                    cnt_d    = ServeLoad;
                    state_d  = StServe;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = StIdle;
            end
        endcase

        run_d = (state_d == StPlay);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            score1_q <= '0;
            score2_q <= '0;
            winner_q <= WinNone;
            run_q    <= 1'b0;
            load_q   <= 1'b0;
            dir_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            score1_q <= score1_d;
            score2_q <= score2_d;
            winner_q <= winner_d;
            run_q    <= run_d;
            load_q   <= load_d;
            dir_q    <= dir_d;
        end
    end

    assign ball_run_o    = run_q;
    assign ball_load_o   = load_q;
    assign serve_dir_y_o = dir_q;
    assign score1_o      = score1_q;
    assign score2_o      = score2_q;
    assign winner_o      = winner_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Bench for pong_game_ctrl: directed vector table, hand sequences for reset,
// win and restart, then random play against a frame-level game model.
module tb_pong_game_ctrl;

    localparam int W    = 3;
    localparam int SF   = 4;
    localparam int PF   = 5;
    localparam int TOPY = 12;
    localparam int BOTY = 452;

    localparam int P_IDLE  = 0;
    localparam int P_SERVE = 1;
    localparam int P_PLAY  = 2;
    localparam int P_POINT = 3;
    localparam int P_OVER  = 4;

    logic       clk = 1'b0;
    logic       rst_ni = 1'b0;
    logic       ft = 1'b0;
    logic       btn = 1'b0;
    logic [8:0] y = 9'd200;
    logic       ball_run, ball_load, serve_dir;
    logic [3:0] score1, score2;
    logic [1:0] winner;
    logic [2:0] state;

    int n_checks = 0;
    int n_err = 0;

    // Game model: phase, frames still to wait, scores, winner, serve direction.
    int m_phase, m_left, m_s1, m_s2, m_win;
    bit m_dir, m_run, m_load;
    bit hist[4];

    typedef struct {
        bit b;
        bit f;
        int yy;
        int st;
        bit run;
        bit load;
        bit dir;
        int s1;
        int s2;
        int win;
    } vec_t;

    vec_t tbl[22];

    pong_game_ctrl #(
        .WIN_SCORE    (W),
        .SERVE_FRAMES (SF),
        .POINT_FRAMES (PF),
        .TOP_GOAL_Y   (TOPY),
        .BOT_GOAL_Y   (BOTY)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_ni),
        .frame_tick_i  (ft),
        .ball_y_i      (y),
        .start_btn_i   (btn),
        .ball_run_o    (ball_run),
        .ball_load_o   (ball_load),
        .serve_dir_y_o (serve_dir),
        .score1_o      (score1),
        .score2_o      (score2),
        .winner_o      (winner),
        .state_o       (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] dut_vec();
        return {state, ball_run, ball_load, serve_dir, score1, score2, winner};
    endfunction

    function automatic logic [15:0] pack(input int st, input bit run, input bit load,
                                         input bit dir, input int s1, input int s2,
                                         input int win);
        return {3'(st), run, load, dir, 4'(s1), 4'(s2), 2'(win)};
    endfunction

    task automatic model_reset();
        m_phase = P_IDLE;
        m_left  = 0;
        m_s1    = 0;
        m_s2    = 0;
        m_win   = 0;
        m_dir   = 1'b0;
        m_run   = 1'b0;
        m_load  = 1'b0;
        for (int i = 0; i < 4; i++) hist[i] = 1'b0;
    endtask

    task automatic begin_serve();
        m_phase = P_SERVE;
        m_left  = SF;
        m_load  = 1'b1;
    endtask

    // hist[k] holds the button as seen k+1 clock edges ago; a press acts 3 edges later.
    task automatic model_edge(input bit b, input bit f, input int yy);
        bit pe;
        pe = hist[2] && !hist[3];
        hist[3] = hist[2];
        hist[2] = hist[1];
        hist[1] = hist[0];
        hist[0] = b;
        m_load = 1'b0;
        case (m_phase)
            P_IDLE: if (pe) begin_serve();
            P_SERVE: if (f) begin
                m_left--;
                if (m_left == 0) m_phase = P_PLAY;
            end
            P_PLAY: if (f) begin
                if (yy <= TOPY) begin
                    m_s1++;
                    m_dir = 1'b1;
                    m_phase = P_POINT;
                    m_left = PF;
                end else if (yy >= BOTY) begin
                    m_s2++;
                    m_dir = 1'b0;
                    m_phase = P_POINT;
                    m_left = PF;
                end
            end
            P_POINT: if (f) begin
                m_left--;
                if (m_left == 0) begin
                    if (m_s1 == W || m_s2 == W) begin
                        m_phase = P_OVER;
                        m_win = (m_s1 == W) ? 1 : 2;
                    end else begin
                        begin_serve();
                    end
                end
            end
            default: if (pe) begin
                m_s1 = 0;
                m_s2 = 0;
                m_win = 0;
                m_dir = 1'b0;
                begin_serve();
            end
        endcase
        m_run = (m_phase == P_PLAY);
    endtask

    task automatic step(input bit b, input bit f, input int yy);
        btn = b;
        ft = f;
        y = 9'(yy);
        @(posedge clk);
        model_edge(b, f, yy);
        #1;
        check("model", dut_vec(), pack(m_phase, m_run, m_load, m_dir, m_s1, m_s2, m_win));
    endtask

    task automatic frames_while(input int phase, input int yy);
        for (int i = 0; i < 40 && m_phase == phase; i++) step(1'b0, 1'b1, yy);
    endtask

    function automatic vec_t mk(input bit b, input bit f, input int yy, input int st,
                                input bit run, input bit load, input bit dir,
                                input int s1, input int s2);
        vec_t v;
        v.b = b; v.f = f; v.yy = yy; v.st = st; v.run = run; v.load = load;
        v.dir = dir; v.s1 = s1; v.s2 = s2; v.win = 0;
        return v;
    endfunction

    initial begin
        bit rb;
        model_reset();

        tbl[0]  = mk(1, 0, 200, P_IDLE,  0, 0, 0, 0, 0);
        tbl[1]  = mk(1, 0, 200, P_IDLE,  0, 0, 0, 0, 0);
        tbl[2]  = mk(1, 0, 200, P_IDLE,  0, 0, 0, 0, 0);
        tbl[3]  = mk(1, 1, 200, P_SERVE, 0, 1, 0, 0, 0);
        tbl[4]  = mk(0, 1, 200, P_SERVE, 0, 0, 0, 0, 0);
        tbl[5]  = mk(0, 1, 200, P_SERVE, 0, 0, 0, 0, 0);
        tbl[6]  = mk(0, 0, 200, P_SERVE, 0, 0, 0, 0, 0);
        tbl[7]  = mk(0, 1, 200, P_SERVE, 0, 0, 0, 0, 0);
        tbl[8]  = mk(0, 1, 200, P_PLAY,  1, 0, 0, 0, 0);
        tbl[9]  = mk(0, 0, 460, P_PLAY,  1, 0, 0, 0, 0);
        tbl[10] = mk(0, 1, 200, P_PLAY,  1, 0, 0, 0, 0);
        tbl[11] = mk(0, 1, 460, P_POINT, 0, 0, 0, 0, 1);
        tbl[12] = mk(1, 1, 200, P_POINT, 0, 0, 0, 0, 1);
        tbl[13] = mk(1, 1, 200, P_POINT, 0, 0, 0, 0, 1);
        tbl[14] = mk(0, 1, 200, P_POINT, 0, 0, 0, 0, 1);
        tbl[15] = mk(1, 1, 200, P_POINT, 0, 0, 0, 0, 1);
        tbl[16] = mk(1, 1, 200, P_SERVE, 0, 1, 0, 0, 1);
        tbl[17] = mk(0, 1, 200, P_SERVE, 0, 0, 0, 0, 1);
        tbl[18] = mk(1, 1, 200, P_SERVE, 0, 0, 0, 0, 1);
        tbl[19] = mk(0, 1, 200, P_SERVE, 0, 0, 0, 0, 1);
        tbl[20] = mk(0, 1, 200, P_PLAY,  1, 0, 0, 0, 1);
        tbl[21] = mk(0, 1, 10,  P_POINT, 0, 0, 1, 1, 1);

        repeat (2) @(posedge clk);
        #1;
        check("reset_state", dut_vec(), 16'h0000);
        rst_ni = 1'b1;

        foreach (tbl[i]) begin
            step(tbl[i].b, tbl[i].f, tbl[i].yy);
            check($sformatf("table_row%0d", i), dut_vec(),
                  pack(tbl[i].st, tbl[i].run, tbl[i].load, tbl[i].dir,
                       tbl[i].s1, tbl[i].s2, tbl[i].win));
        end

        // Second top goal, then back into play with score1 = 2.
        frames_while(P_POINT, 200);
        frames_while(P_SERVE, 200);
        step(1'b0, 1'b1, 8);
        frames_while(P_POINT, 200);
        frames_while(P_SERVE, 200);
        check("pre_reset_state", state, 3'd2);
        check("pre_reset_score1", score1, 4'd2);

        // Asynchronous reset between clock edges.
        #2 rst_ni = 1'b0;
        #1;
        check("async_rst_state", state, 3'd0);
        check("async_rst_run", ball_run, 1'b0);
        check("async_rst_load", ball_load, 1'b0);
        check("async_rst_dir", serve_dir, 1'b0);
        check("async_rst_score1", score1, 4'd0);
        check("async_rst_score2", score2, 4'd0);
        check("async_rst_winner", winner, 2'd0);
        model_reset();
        @(posedge clk);
        #1 rst_ni = 1'b1;

        // Full game to WIN_SCORE via top goals exactly on the goal row.
        repeat (4) step(1'b1, 1'b0, 200);
        check("restart_serve", state, 3'd1);
        for (int g = 0; g < W; g++) begin
            frames_while(P_SERVE, 200);
            step(1'b0, 1'b1, TOPY);
            frames_while(P_POINT, 300);
        end
        check("over_state", state, 3'd4);
        check("over_winner", winner, 2'b01);
        check("over_score1", score1, 4'd3);
        check("over_run", ball_run, 1'b0);
        repeat (5) step(1'b0, 1'b1, 460);
        check("over_hold_score1", score1, 4'd3);
        check("over_hold_state", state, 3'd4);

        repeat (4) step(1'b1, 1'b0, 200);
        check("newgame_state", state, 3'd1);
        check("newgame_load", ball_load, 1'b1);
        check("newgame_score1", score1, 4'd0);
        check("newgame_winner", winner, 2'b00);
        check("newgame_dir", serve_dir, 1'b0);
        frames_while(P_SERVE, 200);
        step(1'b0, 1'b1, BOTY - 1);
        check("bot_edge_nogoal", state, 3'd2);
        step(1'b0, 1'b1, BOTY);
        check("bot_edge_goal_state", state, 3'd3);
        check("bot_edge_goal_score2", score2, 4'd1);

        // Random play.
        rb = 1'b0;
        for (int n = 0; n < 6000; n++) begin
            if ($urandom_range(0, 39) == 0) rb = ~rb;
            step(rb, ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 511))
                                             : int'($urandom_range(13, 451)));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
